// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris gravity path: scheduler states, counter widths
// and the level-to-frames gravity table.
package tetris_pkg;

    localparam int FRAME_W = 20;
    localparam int ROW_W   = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sched_state_e;

    // Frames between fall events at each level, without soft drop.
    function automatic logic [ROW_W-1:0] gravity_frames(input logic [3:0] level);
        logic [ROW_W-1:0] frames;
        case (level)
            4'd0:    frames = 6'd48;
            4'd1:    frames = 6'd43;
            4'd2:    frames = 6'd38;
            4'd3:    frames = 6'd33;
            4'd4:    frames = 6'd28;
            4'd5:    frames = 6'd23;
            4'd6:    frames = 6'd18;
            4'd7:    frames = 6'd13;
            4'd8:    frames = 6'd8;
            4'd9:    frames = 6'd6;
            4'd10:   frames = 6'd5;
            4'd11:   frames = 6'd5;
            4'd12:   frames = 6'd5;
            4'd13:   frames = 6'd4;
            4'd14:   frames = 6'd4;
            default: frames = 6'd3;
        endcase
        return frames;
    endfunction

endpackage

// File: rtl/gravity_scheduler_if.sv
// Control and fall-event handshake between the gravity scheduler (master) and
// the game FSM (slave).
interface gravity_scheduler_if #(
    parameter int LEVEL_W = 4
);
    logic               enable;
    logic               pause;
    logic [LEVEL_W-1:0] level;
    logic               soft_drop;
    logic               restart;
    logic               fall_ready;
    logic               fall_valid;
    logic               frame_tick;
    logic               overrun;
    logic [1:0]         state;

    modport master (
        input  enable, pause, level, soft_drop, restart, fall_ready,
        output fall_valid, frame_tick, overrun, state
    );

    modport slave (
        output enable, pause, level, soft_drop, restart, fall_ready,
        input  fall_valid, frame_tick, overrun, state
    );
endinterface

// File: rtl/frame_tick_gen.sv
// Divides the system clock into frame ticks: one registered pulse every FRAME_DIV
// clocks while run is high; clear reloads the divider and suppresses the pulse.
module frame_tick_gen
    import tetris_pkg::*;
#(
    parameter int unsigned FRAME_DIV = 833333
) (
    input  logic clock_in,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic frame_tick
);

    localparam logic [FRAME_W-1:0] FC_RELOAD = FRAME_W'(FRAME_DIV - 1);

    logic [FRAME_W-1:0] fc_q, fc_d;
    logic               tick_q, tick_d;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        fc_d   = fc_q;
        tick_d = 1'b0;
        if (clear) begin
            fc_d = FC_RELOAD;
        end else if (run) begin
            if (fc_q == '0) begin
                fc_d   = FC_RELOAD;
                tick_d = 1'b1;
            end else begin
                fc_d = fc_q - 1'b1;
            end
        end
    end

    // NOTE: non-blocking assignments make every flop update from the same pre-edge values.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            fc_q   <= FC_RELOAD;
            tick_q <= 1'b0;
        end else begin
            fc_q   <= fc_d;
            tick_q <= tick_d;
        end
    end

    assign frame_tick = tick_q;

endmodule

// File: rtl/gravity_scheduler.sv
// Turns frame ticks into level-paced fall events for the game FSM, with soft-drop
// override, run/pause/restart control and a sticky overrun flag for dropped events.
module gravity_scheduler
    import tetris_pkg::*;
#(
    parameter int unsigned FRAME_DIV   = 833333,
    parameter int unsigned SOFT_FRAMES = 2,
    parameter int          LEVEL_W     = 4
) (
    input  logic clock_in,
    input  logic reset,
    gravity_scheduler_if.master bus
);

    localparam logic [ROW_W-1:0] SOFT_ROWS = ROW_W'(SOFT_FRAMES);

    sched_state_e       state_q, state_d;
    logic [ROW_W-1:0]   rc_q, rc_d;
    logic               fall_valid_q, fall_valid_d;
    logic               overrun_q, overrun_d;

    logic [LEVEL_W-1:0] level_raw;
    logic [3:0]         level_idx;
    logic [ROW_W-1:0]   table_period;
    logic [ROW_W-1:0]   period;
    logic [ROW_W-1:0]   period_m1;
    logic               run;
    logic               active;
    logic               clear;
    logic               frame_tick;
    logic               fall_event;
    logic               accept;

    assign level_raw = bus.level;
    assign level_idx = 4'(level_raw);

    always_comb begin
        table_period = gravity_frames(level_idx);
        period       = (bus.soft_drop && (SOFT_ROWS < table_period)) ? SOFT_ROWS : table_period;
        period_m1    = period - 1'b1;
    end

    assign run    = (state_q == ST_RUN);
    assign active = bus.enable && (state_q != ST_IDLE);
    assign clear  = !active || bus.restart;
    assign accept = fall_valid_q && bus.fall_ready;

    frame_tick_gen #(
        .FRAME_DIV (FRAME_DIV)
    ) u_frame_tick_gen (
        .clock_in   (clock_in),
        .reset      (reset),
        .run        (run),
        .clear      (clear),
        .frame_tick (frame_tick)
    );

    always_comb begin
        state_d = state_q;
        if (!bus.enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   if (bus.pause)  state_d = ST_PAUSE;
                ST_PAUSE: if (!bus.pause) state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // A tick landing on the RUN->PAUSE edge is still consumed during the first paused cycle.
    always_comb begin
        rc_d         = rc_q;
        fall_valid_d = fall_valid_q;
        overrun_d    = overrun_q;
        fall_event   = 1'b0;
        if (!active || bus.restart) begin
            rc_d         = period_m1;
            fall_valid_d = 1'b0;
        end else begin
            if (run && (rc_q > period_m1)) begin
                rc_d = period_m1;
            end else if (frame_tick) begin
                if (rc_q == '0) begin
                    fall_event = 1'b1;
                    rc_d       = period_m1;
                end else begin
                    rc_d = rc_q - 1'b1;
                end
            end

            if (fall_event) begin
                if (fall_valid_q && !accept) begin
                    overrun_d = 1'b1;
                end
                fall_valid_d = 1'b1;
            end else if (accept) begin
                fall_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rc_q         <= period_m1;
            fall_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rc_q         <= rc_d;
            fall_valid_q <= fall_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.fall_valid = fall_valid_q;
    assign bus.frame_tick = frame_tick;
    assign bus.overrun    = overrun_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_gravity_scheduler.sv
// Self-checking bench for gravity_scheduler with a short frame (FRAME_DIV=4); expected
// fall_valid rise cycles are queued as stimulus is applied and matched as rises appear.
module tb_gravity_scheduler;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_q[$];
    logic fv_prev = 1'b0;

    gravity_scheduler_if #(.LEVEL_W(4)) gs_if ();

    gravity_scheduler #(
        .FRAME_DIV   (4),
        .SOFT_FRAMES (2),
        .LEVEL_W     (4)
    ) dut (
        .clock_in (clk),
        .reset    (reset),
        .bus      (gs_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Advance to the next falling edge and score any new fall_valid rise.
    task automatic step();
        int want;
        @(negedge clk);
        if (gs_if.fall_valid === 1'b1 && fv_prev !== 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL fall_rise: rise at cycle %0d, no rise expected", cyc);
            end else begin
                want = exp_q.pop_front();
                if (cyc !== want) begin
                    errors++;
                    $display("FAIL fall_rise: rise at cycle %0d, expected cycle %0d", cyc, want);
                end
            end
        end
        fv_prev = gs_if.fall_valid;
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic drain_check(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected fall rises never seen, next at cycle %0d",
                     name, exp_q.size(), exp_q[0]);
        end
        exp_q.delete();
    endtask

    task automatic expect_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b expected %b at cycle %0d", name, got, want, cyc);
        end
    endtask

    task automatic expect_state(input string name, input logic [1:0] want);
        checks++;
        if (gs_if.state !== want) begin
            errors++;
            $display("FAIL %s: state got %0d expected %0d at cycle %0d", name, gs_if.state, want, cyc);
        end
    endtask

    // Reset for one cycle with enable high; returns the edge on which RUN is entered.
    task automatic start_run(input logic [3:0] lvl, input logic rdy, output int e);
        exp_q.delete();
        reset            = 1'b1;
        gs_if.enable     = 1'b1;
        gs_if.pause      = 1'b0;
        gs_if.soft_drop  = 1'b0;
        gs_if.restart    = 1'b0;
        gs_if.level      = lvl;
        gs_if.fall_ready = rdy;
        step();
        reset = 1'b0;
        e     = cyc + 1;
    endtask

    task automatic test_reset();
        reset            = 1'b1;
        gs_if.enable     = 1'b0;
        gs_if.pause      = 1'b0;
        gs_if.soft_drop  = 1'b0;
        gs_if.restart    = 1'b0;
        gs_if.level      = 4'd0;
        gs_if.fall_ready = 1'b1;
        step();
        step();
        expect_state("reset_state", 2'd0);
        expect_bit("reset_fall_valid", gs_if.fall_valid, 1'b0);
        expect_bit("reset_frame_tick", gs_if.frame_tick, 1'b0);
        expect_bit("reset_overrun", gs_if.overrun, 1'b0);
        reset = 1'b0;
        step();
        step();
        expect_state("idle_without_enable", 2'd0);
        expect_bit("idle_no_tick", gs_if.frame_tick, 1'b0);
    endtask

    task automatic test_basic_rate();
        int e;
        int n;
        start_run(4'd0, 1'b1, e);
        exp_q.push_back(e + 193);
        while (cyc < e + 200) begin
            step();
            n = cyc - e;
            expect_bit("basic_frame_tick", gs_if.frame_tick, (n > 0) && (n % 4 == 0));
            if (n == 1)   expect_state("basic_run_state", 2'd1);
            if (n == 194) expect_bit("basic_fall_one_cycle", gs_if.fall_valid, 1'b0);
        end
        drain_check("basic_falls");
    endtask

    task automatic test_level_change();
        int e;
        start_run(4'd15, 1'b1, e);
        exp_q.push_back(e + 13);
        exp_q.push_back(e + 25);
        exp_q.push_back(e + 217);
        wait_to(e + 22);
        gs_if.level = 4'd0;
        wait_to(e + 225);
        drain_check("level_change_falls");
    endtask

    task automatic test_soft_drop();
        int e;
        start_run(4'd0, 1'b1, e);
        exp_q.push_back(e + 77);
        exp_q.push_back(e + 85);
        exp_q.push_back(e + 93);
        exp_q.push_back(e + 285);
        wait_to(e + 69);
        gs_if.soft_drop = 1'b1;
        wait_to(e + 89);
        gs_if.soft_drop = 1'b0;
        wait_to(e + 290);
        drain_check("soft_drop_falls");
    endtask

    task automatic test_overrun();
        int e;
        start_run(4'd15, 1'b0, e);
        exp_q.push_back(e + 13);
        wait_to(e + 24);
        gs_if.fall_ready = 1'b1;
        step();
        gs_if.fall_ready = 1'b0;
        expect_bit("accept_with_event_valid", gs_if.fall_valid, 1'b1);
        expect_bit("accept_with_event_no_overrun", gs_if.overrun, 1'b0);
        wait_to(e + 36);
        expect_bit("overrun_before_drop", gs_if.overrun, 1'b0);
        step();
        expect_bit("overrun_after_drop", gs_if.overrun, 1'b1);
        expect_bit("valid_held_after_drop", gs_if.fall_valid, 1'b1);
        wait_to(e + 40);
        gs_if.fall_ready = 1'b1;
        step();
        expect_bit("valid_cleared_on_accept", gs_if.fall_valid, 1'b0);
        expect_bit("overrun_sticky", gs_if.overrun, 1'b1);
        exp_q.push_back(e + 49);
        wait_to(e + 50);
        expect_bit("valid_cleared_again", gs_if.fall_valid, 1'b0);
        expect_bit("overrun_still_sticky", gs_if.overrun, 1'b1);
        drain_check("overrun_falls");
    endtask

    task automatic test_pause_enable();
        int e;
        int n;
        start_run(4'd15, 1'b0, e);
        exp_q.push_back(e + 33);
        wait_to(e + 5);
        gs_if.pause = 1'b1;
        while (cyc < e + 34) begin
            step();
            n = cyc - e;
            expect_bit("pause_frame_tick", gs_if.frame_tick, (n == 28) || (n == 32));
            if (n == 15) expect_state("pause_state", 2'd2);
            if (n == 27) expect_state("resume_state", 2'd1);
            if (n == 25) gs_if.pause = 1'b0;
        end
        expect_bit("valid_before_disable", gs_if.fall_valid, 1'b1);
        gs_if.enable = 1'b0;
        step();
        expect_state("disable_state", 2'd0);
        expect_bit("disable_fall_valid", gs_if.fall_valid, 1'b0);
        expect_bit("disable_frame_tick", gs_if.frame_tick, 1'b0);
        drain_check("pause_falls");
    endtask

    task automatic test_restart_reset();
        int e;
        int n;
        start_run(4'd15, 1'b0, e);
        wait_to(e + 12);
        gs_if.restart = 1'b1;
        step();
        gs_if.restart = 1'b0;
        expect_bit("restart_discards_event", gs_if.fall_valid, 1'b0);
        expect_bit("restart_no_tick", gs_if.frame_tick, 1'b0);
        exp_q.push_back(e + 26);
        while (cyc < e + 26) begin
            step();
            n = cyc - e;
            expect_bit("restart_frame_tick", gs_if.frame_tick, (n == 17) || (n == 21) || (n == 25));
        end
        expect_bit("valid_before_reset", gs_if.fall_valid, 1'b1);
        reset = 1'b1;
        step();
        expect_state("midrun_reset_state", 2'd0);
        expect_bit("midrun_reset_fall_valid", gs_if.fall_valid, 1'b0);
        expect_bit("midrun_reset_frame_tick", gs_if.frame_tick, 1'b0);
        expect_bit("midrun_reset_overrun", gs_if.overrun, 1'b0);
        reset = 1'b0;
        drain_check("restart_falls");
    endtask

    initial begin
        test_reset();
        test_basic_rate();
        test_level_change();
        test_soft_drop();
        test_overrun();
        test_pause_enable();
        test_restart_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gravity_scheduler.md
Name: gravity_scheduler

Overview:
- Sequences piece gravity for the Tetris game FSM.
- Divides the system clock into 60 Hz frame ticks, then divides frames into fall events at a level-dependent rate.
- Soft drop overrides the rate to a faster one.
- Each fall event goes to the game FSM through a valid/ready handshake. Run, pause and restart are controlled by the FSM.

Parameters:
- FRAME_DIV, 833333, clocks per frame (60 Hz at 50 MHz); 20-bit, must be ≥ 2.
- SOFT_FRAMES, 2, frames per fall while soft_drop is held; must be ≥ 1.
- LEVEL_W, 4, level input width (16 levels).

Ports:
- clock_in  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  game running; 0 forces IDLE.
- pause  in  1  freeze counters while high.
- level  in  LEVEL_W  current level, 0–15.
- soft_drop  in  1  soft-drop key held.
- restart  in  1  one-cycle pulse on piece spawn.
- fall_ready  in  1  FSM accepts fall event.
- fall_valid  out  1  fall event pending.
- frame_tick  out  1  one-cycle pulse per frame.
- overrun  out  1  sticky: a fall event was dropped.
- state  out  2  0 IDLE, 1 RUN, 2 PAUSE.

Behaviour:
- Reset values: state=IDLE, fall_valid=0, frame_tick=0, overrun=0, fc=FRAME_DIV-1, rc=period-1.
- Priority: reset > !enable > restart > pause > normal counting.
- Period table, in frames, levels 0–15: 48,43,38,33,28,23,18,13,8,6,5,5,5,4,4,3.
- period = soft_drop ? min(SOFT_FRAMES, table[level]) : table[level]. Computed combinationally each cycle.
- Frame counter fc, 20-bit:
  - In RUN it decrements each clock; at 0 it reloads FRAME_DIV-1.
  - frame_tick is registered, high in the cycle after fc==0.
  - First tick comes exactly FRAME_DIV clocks after the IDLE→RUN edge, then every FRAME_DIV clocks.
- Row counter rc, 6-bit, acts only on frame_tick:
  - If rc==0: fall event; rc reloads period-1.
  - Else: rc decrements.
- Clamp: in any RUN cycle where rc > period-1, rc loads period-1. This covers soft-drop press and level change. Clamp takes precedence over a decrement in the same cycle.
- Fall handshake:
  - A fall event sets fall_valid on the next edge.
  - fall_valid holds until a cycle with fall_valid & fall_ready, which clears it.
  - Event in the same cycle as an accept: fall_valid stays 1, no overrun.
  - Event while fall_valid=1 and not accepted: event dropped, overrun←1. overrun clears only on reset.
- FSM:
  - IDLE→RUN when enable.
  - RUN→PAUSE when pause.
  - PAUSE→RUN when !pause.
  - Any state→IDLE when !enable.
- IDLE: fc and rc held at reload values; fall_valid forced 0; frame_tick 0.
- PAUSE: fc and rc frozen; no frame_tick; fall_valid retained; handshake still accepts.
- restart (RUN or PAUSE): fc←FRAME_DIV-1, rc←period-1, fall_valid←0. A fall event in the same cycle is discarded.
- Latency: fall_valid rises 1 clock after the frame_tick on which rc==0.

Decomposition:
- Shared package tetris_pkg:
  - state encodings: ST_IDLE, ST_RUN, ST_PAUSE;
  - GRAVITY_FRAMES lookup constant/function (16×6-bit);
  - frame width constant FRAME_W=20.
- Sub-module frame_tick_gen (FRAME_DIV parameter; ports clock_in, reset, run, clear, frame_tick).
- The row counter, clamp, handshake and FSM live in gravity_scheduler.

Test Plan:
- FRAME_DIV=4, enable=1, level=0, fall_ready=1 → frame_tick every 4 clocks, first at clock 4. One-cycle fall_valid 1 clock after the 48th frame_tick (clock 193).
- level=15 → falls every 3 frames = every 12 clocks; switch to level=0 mid-count → next fall after 48 frames, no early event.
- level=0, soft_drop=1 when rc=30 → rc clamps to 1; fall on the 2nd following frame_tick; afterwards every 2 frames. Release → next period 48.
- fall_ready=0 across two fall events → fall_valid stays 1, overrun=1 after the second event. fall_ready=1 → fall_valid clears; overrun stays 1 until reset.
- pause for 20 clocks mid-frame → no frame_tick; fc/rc resume from frozen values, so the frame is delayed exactly 20 clocks. enable=0 → state IDLE next clock, fall_valid=0.
- restart coincident with a fall event → fall_valid stays 0, next frame_tick 4 clocks later, next fall after full period. reset mid-RUN → all outputs at reset values on the next clock.
